vcond_unit: RTL

- Per-lane condition unit for the vector execute stage. Holds an NZCV flag register per lane.
- Evaluates the full 4-bit condition field against each lane's stored flags and produces per-lane write masks for the E/M boundary.
- Reduces the lane results into a single branch decision: lane 0, ANY, or ALL.
- Contains the registered E→M pipeline stage with stall and flush. Sits between the vector ALU and the M-stage write-enable logic.

---
 rtl/vcond_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vcond_unit.sv
// Per-lane NZCV condition unit with E->M register: M outputs 1 cycle after E, held on stall_e, cleared on flush_e.
// Optional saturating statistics counters are built when VCU_STATS_EN is defined.
module vcond_unit #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_e,
  input  logic                 stall_e,
  input  logic                 flush_e,
  input  logic                 vec_e,
  input  logic [LANES-1:0]     lane_en_e,
  input  logic [3:0]           cond_e,
  input  logic [1:0]           flag_write_e,
  input  logic [4*LANES-1:0]   alu_flags,
  input  logic [1:0]           branch_mode_e,
  input  logic                 reg_write_e,
  input  logic                 mem_write_e,
  input  logic                 pcsrc_e,
  input  logic                 branch_e,
  output logic                 branch_taken_e,
  output logic [LANES-1:0]     reg_write_m,
  output logic [LANES-1:0]     mem_write_m,
  output logic                 pcsrc_m,
  output logic                 valid_m,
  output logic [4*LANES-1:0]   flags_q
`ifdef VCU_STATS_EN
  ,
  output logic [CNT_W-1:0]     stat_exec,
  output logic [CNT_W-1:0]     stat_squash,
  output logic [CNT_W-1:0]     stat_btaken
`endif
);

  // f is {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = cy;
      4'h3:    cond_pass = ~cy;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = cy & ~z;
      4'h9:    cond_pass = ~(cy & ~z);
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = ~(~z & (n == v));
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  logic [LANES-1:0]   act;
  logic [LANES-1:0]   cx;
  logic [LANES-1:0]   gmask;
  logic               red;
  logic               upd;
  logic [4*LANES-1:0] flags_d;
  logic               valid_m_d;
  logic               pcsrc_m_d;
  logic [LANES-1:0]   reg_write_m_d;
  logic [LANES-1:0]   mem_write_m_d;

  always_comb begin
    act = '0;
    cx  = '0;
    for (int i = 0; i < LANES; i++) begin
      act[i] = vec_e ? lane_en_e[i] : (i == 0);
      cx[i]  = act[i] & cond_pass(cond_e, flags_q[4*i +: 4]);
    end
    // Scalar ops broadcast the lane-0 result so every lane's write enable follows it.
    gmask = vec_e ? cx : {LANES{cx[0]}};
    case (branch_mode_e)
      2'b01:   red = |cx;
      2'b10:   red = (act != '0) && (cx == act);
      default: red = cx[0];
    endcase
  end

  assign branch_taken_e = valid_e & ~flush_e & branch_e & red;
  assign upd            = valid_e & ~stall_e & ~flush_e;

  always_comb begin
    flags_d = flags_q;
    if (upd) begin
      for (int i = 0; i < LANES; i++) begin
        if (cx[i] && flag_write_e[1]) flags_d[4*i+2 +: 2] = alu_flags[4*i+2 +: 2];
        if (cx[i] && flag_write_e[0]) flags_d[4*i   +: 2] = alu_flags[4*i   +: 2];
      end
    end
  end

  always_comb begin
    valid_m_d     = valid_m;
    pcsrc_m_d     = pcsrc_m;
    reg_write_m_d = reg_write_m;
    mem_write_m_d = mem_write_m;
    if (flush_e) begin
      valid_m_d     = 1'b0;
      pcsrc_m_d     = 1'b0;
      reg_write_m_d = '0;
      mem_write_m_d = '0;
    end else if (!stall_e) begin
      valid_m_d     = valid_e;
      pcsrc_m_d     = pcsrc_e & valid_e & red;
      reg_write_m_d = {LANES{reg_write_e & valid_e}} & gmask;
      mem_write_m_d = {LANES{mem_write_e & valid_e}} & gmask;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q     <= '0;
      valid_m     <= 1'b0;
      pcsrc_m     <= 1'b0;
      reg_write_m <= '0;
      mem_write_m <= '0;
    end else begin
      flags_q     <= flags_d;
      valid_m     <= valid_m_d;
      pcsrc_m     <= pcsrc_m_d;
      reg_write_m <= reg_write_m_d;
      mem_write_m <= mem_write_m_d;
    end
  end

`ifdef VCU_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_exec   <= '0;
      stat_squash <= '0;
      stat_btaken <= '0;
    end else begin
      if (upd && gmask != '0 && stat_exec != '1)   stat_exec   <= stat_exec + CNT_W'(1);
      if (upd && gmask == '0 && stat_squash != '1) stat_squash <= stat_squash + CNT_W'(1);
      if (branch_taken_e && !stall_e && stat_btaken != '1) stat_btaken <= stat_btaken + CNT_W'(1);
    end
  end
`endif

endmodule
